// File: rtl/syscall_pkg.sv
// syscall_pkg
//   Shared constants for the syscall service unit: syscall numbers, the
//   destination register, FSM state encodings and the 10^k table used by
//   the integer-to-decimal converter.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_READ_INT   = 32'd5;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [4:0] REG_V0 = 5'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_STR_FETCH  = 3'd1;
  localparam state_t ST_STR_EMIT   = 3'd2;
  localparam state_t ST_INT_DIGIT  = 3'd3;
  localparam state_t ST_READ_WAIT  = 3'd4;
  localparam state_t ST_EXIT_DRAIN = 3'd5;
  localparam state_t ST_DONE       = 3'd6;
  localparam state_t ST_HALTED     = 3'd7;

  function automatic logic [31:0] pow10(input logic [3:0] k);
    logic [31:0] v;
    case (k)
      4'd0:    v = 32'd1;
      4'd1:    v = 32'd10;
      4'd2:    v = 32'd100;
      4'd3:    v = 32'd1000;
      4'd4:    v = 32'd10000;
      4'd5:    v = 32'd100000;
      4'd6:    v = 32'd1000000;
      4'd7:    v = 32'd10000000;
      4'd8:    v = 32'd100000000;
      4'd9:    v = 32'd1000000000;
      default: v = 32'd1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/syscall_unit_char_fifo.sv
// sys_char_fifo
//   Character FIFO between the syscall FSM and the console sink.
//   Pointers carry one extra wrap bit to tell full from empty.
// Ports
//   i_clk, i_reset     clock, synchronous active-high reset (flushes FIFO)
//   i_push, i_data     write strobe / character; taken when not full or
//                      when a pop happens in the same cycle
//   i_pop              read strobe; ignored when empty
//   o_data             head character
//   o_full, o_empty    occupancy flags
module sys_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot being written is the one being read out this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/syscall_unit.sv
// syscall_unit
//   Syscall service unit beside the MIPS register file and data memory.
//   Decodes $v0 on a syscall strobe: print int (1), print string (4),
//   read int (5), exit (10). Characters stream through sys_char_fifo to
//   the console sink. The core stalls while o_sys_busy is high.
//   Optional feature macro SYSCALL_PRINT_CHAR_EN: enables code 11 (print
//   sys_arg[7:0]); without it code 11 is an unknown code.
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_sys_req/code/arg          syscall strobe, $v0, $a0
//   o_sys_busy/done/err         handshake back to the core
//   o_mem_rd_*, i_mem_rd_*      word-read port into data memory
//   o_ch_valid/data, i_ch_ready console character stream
//   i_in_valid/data, o_in_ready integer input source
//   o_rf_wr_en/addr/data        write of the read integer into $v0
//   o_halt                      sticky stop after exit
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_STR    = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sys_req,
  input  logic [31:0]       i_sys_code,
  input  logic [31:0]       i_sys_arg,
  output logic              o_sys_busy,
  output logic              o_sys_done,
  output logic              o_sys_err,
  output logic              o_mem_rd_req,
  output logic [ADDR_W-3:0] o_mem_rd_addr,
  input  logic              i_mem_rd_ack,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_ch_valid,
  output logic [7:0]        o_ch_data,
  input  logic              i_ch_ready,
  input  logic              i_in_valid,
  input  logic [31:0]       i_in_data,
  output logic              o_in_ready,
  output logic              o_rf_wr_en,
  output logic [4:0]        o_rf_wr_addr,
  output logic [31:0]       o_rf_wr_data,
  output logic              o_halt
);

  localparam int CNT_W = $clog2(MAX_STR + 1);

  state_t            r_state;
  logic              r_err;
  logic              r_exit;
  logic              r_halt;
  logic              r_char;
  logic              r_neg;
  logic              r_started;
  logic [31:0]       r_val;
  logic [3:0]        r_k;
  logic [3:0]        r_digit;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rf_wr_en;
  logic [31:0]       r_rf_wr_data;

  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push_ok;
  logic       w_want;
  logic       w_push;
  logic [7:0] w_byte;
  logic [7:0] w_lane_byte;
  logic [31:0] w_pow;
  logic       w_ge;
  logic       w_emit_digit;

  sys_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_byte),
    .i_pop   (w_pop),
    .o_data  (o_ch_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop        = o_ch_valid && i_ch_ready;
  assign w_push_ok    = !w_full || w_pop;
  assign w_lane_byte  = r_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_pow        = pow10(r_k);
  assign w_ge         = (r_val >= w_pow);
  // A finished digit is printed unless it is a leading zero; the units digit always prints.
  assign w_emit_digit = !w_ge && ((r_digit != 4'd0) || r_started || (r_k == 4'd0));

  always_comb begin
    w_want = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      ST_INT_DIGIT: begin
        if (r_char) begin
          w_want = 1'b1;
          w_byte = r_val[7:0];
        end else if (r_neg) begin
          w_want = 1'b1;
          w_byte = 8'h2D;
        end else if (w_emit_digit) begin
          w_want = 1'b1;
          w_byte = 8'h30 + {4'h0, r_digit};
        end
      end
      ST_STR_EMIT: begin
        if (w_lane_byte != 8'h00) begin
          w_want = 1'b1;
          w_byte = w_lane_byte;
        end
      end
      default: ;
    endcase
  end

  assign w_push = w_want && w_push_ok;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_err        <= 1'b0;
      r_exit       <= 1'b0;
      r_halt       <= 1'b0;
      r_char       <= 1'b0;
      r_neg        <= 1'b0;
      r_started    <= 1'b0;
      r_val        <= '0;
      r_k          <= '0;
      r_digit      <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_cnt        <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_data <= '0;
    end else begin
      r_rf_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_sys_req) begin
            r_err     <= 1'b0;
            r_exit    <= 1'b0;
            r_char    <= 1'b0;
            r_neg     <= 1'b0;
            r_started <= 1'b0;
            r_digit   <= '0;
            r_k       <= 4'd9;
            r_cnt     <= '0;
            r_addr    <= i_sys_arg[ADDR_W-1:0];
            r_val     <= i_sys_arg;
            if (i_sys_code == SYS_PRINT_INT) begin
              r_neg   <= i_sys_arg[31];
              // Two's-complement magnitude; 0x80000000 maps to 2147483648 unsigned.
              r_val   <= i_sys_arg[31] ? (~i_sys_arg + 32'd1) : i_sys_arg;
              r_state <= ST_INT_DIGIT;
            end else if (i_sys_code == SYS_PRINT_STR) begin
              r_state <= ST_STR_FETCH;
            end else if (i_sys_code == SYS_READ_INT) begin
              r_state <= ST_READ_WAIT;
            end else if (i_sys_code == SYS_EXIT) begin
              r_exit  <= 1'b1;
              r_state <= ST_EXIT_DRAIN;
`ifdef SYSCALL_PRINT_CHAR_EN
            end else if (i_sys_code == SYS_PRINT_CHAR) begin
              r_char  <= 1'b1;
              r_state <= ST_INT_DIGIT;
`endif
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_STR_FETCH: begin
          if (i_mem_rd_ack) begin
            r_word  <= i_mem_rd_data;
            r_state <= ST_STR_EMIT;
          end
        end
        ST_STR_EMIT: begin
          if (w_lane_byte == 8'h00) begin
            r_state <= ST_DONE;
          end else if (w_push) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(MAX_STR - 1)) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else if (r_addr[1:0] == 2'd3) begin
              r_state <= ST_STR_FETCH;
            end
          end
        end
        ST_INT_DIGIT: begin
          if (r_char) begin
            if (w_push) r_state <= ST_DONE;
          end else if (r_neg) begin
            if (w_push) r_neg <= 1'b0;
          end else if (w_ge) begin
            r_val   <= r_val - w_pow;
            r_digit <= r_digit + 4'd1;
          end else if (w_emit_digit) begin
            if (w_push) begin
              r_started <= 1'b1;
              r_digit   <= '0;
              if (r_k == 4'd0) r_state <= ST_DONE;
              else             r_k     <= r_k - 4'd1;
            end
          end else begin
            r_k <= r_k - 4'd1;
          end
        end
        ST_READ_WAIT: begin
          // Capture cycle, then one cycle with the write pulse, then DONE.
          if (r_rf_wr_en) begin
            r_state <= ST_DONE;
          end else if (i_in_valid) begin
            r_rf_wr_en   <= 1'b1;
            r_rf_wr_data <= i_in_data;
          end
        end
        ST_EXIT_DRAIN: begin
          if (w_empty) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (r_exit) begin
            r_halt  <= 1'b1;
            r_state <= ST_HALTED;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sys_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_HALTED);
  assign o_sys_done    = (r_state == ST_DONE);
  assign o_sys_err     = (r_state == ST_DONE) && r_err;
  assign o_mem_rd_req  = (r_state == ST_STR_FETCH);
  assign o_mem_rd_addr = r_addr[ADDR_W-1:2];
  assign o_ch_valid    = !w_empty;
  assign o_in_ready    = (r_state == ST_READ_WAIT) && !r_rf_wr_en;
  assign o_rf_wr_en    = r_rf_wr_en;
  assign o_rf_wr_addr  = REG_V0;
  assign o_rf_wr_data  = r_rf_wr_data;
  // Halt rises together with the exit completion pulse and then sticks.
  assign o_halt        = r_halt || ((r_state == ST_DONE) && r_exit);

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  localparam int ADDR_W  = 11;
  localparam int DEPTH   = 2;
  localparam int MAX_STR = 256;
  localparam int MEM_B   = 1 << ADDR_W;

  logic              clk;
  logic              i_reset;
  logic              i_sys_req;
  logic [31:0]       i_sys_code;
  logic [31:0]       i_sys_arg;
  logic              o_sys_busy;
  logic              o_sys_done;
  logic              o_sys_err;
  logic              o_mem_rd_req;
  logic [ADDR_W-3:0] o_mem_rd_addr;
  logic              i_mem_rd_ack;
  logic [31:0]       i_mem_rd_data;
  logic              o_ch_valid;
  logic [7:0]        o_ch_data;
  logic              i_ch_ready;
  logic              i_in_valid;
  logic [31:0]       i_in_data;
  logic              o_in_ready;
  logic              o_rf_wr_en;
  logic [4:0]        o_rf_wr_addr;
  logic [31:0]       o_rf_wr_data;
  logic              o_halt;

  syscall_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MAX_STR(MAX_STR)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_sys_req(i_sys_req), .i_sys_code(i_sys_code), .i_sys_arg(i_sys_arg),
    .o_sys_busy(o_sys_busy), .o_sys_done(o_sys_done), .o_sys_err(o_sys_err),
    .o_mem_rd_req(o_mem_rd_req), .o_mem_rd_addr(o_mem_rd_addr),
    .i_mem_rd_ack(i_mem_rd_ack), .i_mem_rd_data(i_mem_rd_data),
    .o_ch_valid(o_ch_valid), .o_ch_data(o_ch_data), .i_ch_ready(i_ch_ready),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_data(o_rf_wr_data),
    .o_halt(o_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [MEM_B/4];
  logic [7:0]  exp_ch[$];
  logic [1:0]  exp_done[$];   // {halt, err}
  logic [31:0] exp_rf[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          rdy_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int unsigned a);
    logic [31:0] w;
    w = mem[(a % MEM_B) / 4];
    return w[8*(a%4) +: 8];
  endfunction

  // Console sink with random backpressure.
  always @(posedge clk) begin
    #1;
    i_ch_ready = rdy_en ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // Data memory read responder with random latency; ack lasts one cycle.
  always @(posedge clk) begin
    #1;
    if (i_mem_rd_ack) i_mem_rd_ack = 1'b0;
    else if (o_mem_rd_req && $urandom_range(0, 2) == 0) begin
      i_mem_rd_ack  = 1'b1;
      i_mem_rd_data = mem[o_mem_rd_addr];
    end
  end

  // Monitors: pop expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_ch_valid && i_ch_ready) begin
        if (exp_ch.size() == 0) chk("char_unexpected", o_ch_valid, 0);
        else chk("char", o_ch_data, exp_ch.pop_front());
      end
      if (o_sys_done) begin
        if (exp_done.size() == 0) chk("done_unexpected", o_sys_done, 0);
        else begin
          logic [1:0] e;
          e = exp_done.pop_front();
          chk("sys_err", o_sys_err, e[0]);
          chk("halt_at_done", o_halt, e[1]);
        end
      end
      if (o_rf_wr_en) begin
        if (exp_rf.size() == 0) chk("rf_unexpected", o_rf_wr_en, 0);
        else begin
          chk("rf_data", o_rf_wr_data, exp_rf.pop_front());
          chk("rf_addr", o_rf_wr_addr, 2);
        end
      end
    end
  end

  task automatic model(input logic [31:0] code, input logic [31:0] arg);
    string       s;
    int          n;
    int unsigned a;
    case (code)
      32'd1: begin
        s = $sformatf("%0d", $signed(arg));
        for (int i = 0; i < s.len(); i++) exp_ch.push_back(s[i]);
        exp_done.push_back(2'b00);
      end
      32'd4: begin
        a = arg % MEM_B;
        n = 0;
        while (n < MAX_STR && mem_byte(a) != 8'h00) begin
          exp_ch.push_back(mem_byte(a));
          n++;
          a = (a + 1) % MEM_B;
        end
        exp_done.push_back({1'b0, n == MAX_STR});
      end
      32'd5:  exp_done.push_back(2'b00);
      32'd10: exp_done.push_back(2'b10);
`ifdef SYSCALL_PRINT_CHAR_EN
      32'd11: begin
        exp_ch.push_back(arg[7:0]);
        exp_done.push_back(2'b00);
      end
`endif
      default: exp_done.push_back(2'b01);
    endcase
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after sys_done.
  task automatic issue(input logic [31:0] code, input logic [31:0] arg,
                       input int rd_delay, input logic [31:0] rd_val, output int lat);
    model(code, arg);
    if (code == 32'd5) exp_rf.push_back(rd_val);
    i_sys_req  = 1'b1;
    i_sys_code = code;
    i_sys_arg  = arg;
    @(posedge clk);
    #1;
    i_sys_req  = 1'b0;
    i_sys_code = $urandom;
    i_sys_arg  = $urandom;
    @(negedge clk);
    lat = 1;
    chk("accepted", o_sys_busy | o_sys_done, 1);
    while (!o_sys_done && lat < 6000) begin
      if (code == 32'd5 && lat == rd_delay) begin
        i_in_valid = 1'b1;
        i_in_data  = rd_val;
      end
      @(negedge clk);
      lat++;
    end
    chk("done_seen", o_sys_done, 1);
    i_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && exp_ch.size() != 0; i++) @(negedge clk);
    chk("drained", exp_ch.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int lat;

  initial begin
    i_reset = 1'b1; i_sys_req = 1'b0; i_sys_code = '0; i_sys_arg = '0;
    i_mem_rd_ack = 1'b0; i_mem_rd_data = '0; i_ch_ready = 1'b0;
    i_in_valid = 1'b0; i_in_data = '0;

    for (int w = 0; w < MEM_B/4; w++)
      for (int b = 0; b < 4; b++)
        mem[w][8*b +: 8] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    mem[9'h040] = 32'h6C6C6548;
    mem[9'h041] = 32'h0000216F;
    for (int w = 9'h100; w < 9'h150; w++)
      for (int b = 0; b < 4; b++) mem[w][8*b +: 8] = 8'($urandom_range(1, 255));

    repeat (3) @(negedge clk);
    chk("rst_busy", o_sys_busy, 0);
    chk("rst_done", o_sys_done, 0);
    chk("rst_err", o_sys_err, 0);
    chk("rst_memreq", o_mem_rd_req, 0);
    chk("rst_chvalid", o_ch_valid, 0);
    chk("rst_inready", o_in_ready, 0);
    chk("rst_rfwr", o_rf_wr_en, 0);
    chk("rst_rfaddr", o_rf_wr_addr, 2);
    chk("rst_halt", o_halt, 0);
    i_reset = 1'b0;
    rdy_en  = 1;
    @(negedge clk);

    issue(32'd1, -32'sd305, 0, 0, lat);
    issue(32'd4, 32'h102, 0, 0, lat);
    issue(32'd1, 32'h80000000, 0, 0, lat);
    issue(32'd4, 32'hFFFF_F7FE, 0, 0, lat);
    drain();

    // Console stalled: the single '0' must wait in the FIFO.
    rdy_en = 0;
    issue(32'd1, 32'd0, 0, 0, lat);
    repeat (40) @(negedge clk);
    chk("held_valid", o_ch_valid, 1);
    chk("held_data", o_ch_data, 8'h30);
    rdy_en = 1;
    drain();

    issue(32'd5, 32'd0, 7, 32'd42, lat);
    i_in_valid = 1'b1;
    i_in_data  = 32'hDEAD_0005;
    issue(32'd5, 32'd0, -1, 32'hDEAD_0005, lat);
    chk("rd_latency", lat, 3);

    issue(32'd4, 32'h400, 0, 0, lat);
    issue(32'd7, 32'd99, 0, 0, lat);
    issue(32'd11, 32'h41, 0, 0, lat);
    drain();

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0, 1:    issue(32'd1, $urandom, 0, 0, lat);
        2:       issue(32'd1, 32'($urandom_range(0, 999)), 0, 0, lat);
        3, 4:    issue(32'd4, $urandom, 0, 0, lat);
        5:       issue(32'd5, 0, $urandom_range(0, 5), $urandom, lat);
        6:       issue(32'd11, $urandom, 0, 0, lat);
        default: issue($urandom_range(12, 40), $urandom, 0, 0, lat);
      endcase
    end
    drain();

    issue(32'd1, 32'd123, 0, 0, lat);
    issue(32'd10, 32'd0, 0, 0, lat);
    chk("halt_sticky", o_halt, 1);
    i_sys_req = 1'b1; i_sys_code = 32'd1; i_sys_arg = 32'd5;
    @(posedge clk); #1 i_sys_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("halted_busy", o_sys_busy, 0);
    chk("halted_halt", o_halt, 1);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst2_halt", o_halt, 0);

    // Second run: reset in the middle of a long string.
    rdy_en = 0;
    i_sys_req = 1'b1; i_sys_code = 32'd4; i_sys_arg = 32'h400;
    @(posedge clk); #1 i_sys_req = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy", o_sys_busy, 1);
    chk("mid_valid", o_ch_valid, 1);
    i_reset = 1'b1;
    @(negedge clk);
    exp_ch.delete();
    exp_done.delete();
    @(negedge clk);
    chk("abort_valid", o_ch_valid, 0);
    chk("abort_busy", o_sys_busy, 0);
    chk("abort_memreq", o_mem_rd_req, 0);
    chk("abort_halt", o_halt, 0);
    i_reset = 1'b0;
    rdy_en  = 1;
    @(negedge clk);
    issue(32'd1, -32'sd77, 0, 0, lat);
    drain();
    chk("done_queue_empty", exp_done.size(), 0);
    chk("rf_queue_empty", exp_rf.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
